// File: rtl/rom_loader_if.sv
// ROM and SRAM bus bundle of the boot-time ROM-to-SRAM copy engine.
// The master side is the copy engine; the slave side holds the two memories.
interface rom_loader_if #(
   parameter int unsigned AW  = 14,
   parameter int unsigned DAW = 19
);
   logic [AW-1:0]  rom_a;
   logic [7:0]     rom_dout;
   logic [DAW-1:0] sram_a;
   logic [7:0]     sram_dout;
   logic [7:0]     sram_din;
   logic           sram_we_n;

   modport master (
      output rom_a,
      input  rom_dout,
      output sram_a,
      output sram_dout,
      input  sram_din,
      output sram_we_n
   );

   modport slave (
      input  rom_a,
      output rom_dout,
      input  sram_a,
      input  sram_dout,
      output sram_din,
      input  sram_we_n
   );
endinterface

// File: rtl/rom_loader.sv
// Copies LEN bytes from the boot ROM into SRAM at a programmable base, then reads
// every byte back and compares it against the ROM; reports checksum and first bad offset.
module rom_loader #(
   parameter int unsigned AW        = 14,
   parameter int unsigned DAW       = 19,
   parameter int unsigned LEN       = 16384,
   parameter int unsigned WE_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [DAW-1:0]  base,
   rom_loader_if.master    mem,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [AW-1:0]   err_addr,
   output logic [7:0]      checksum
);

   localparam logic [AW-1:0] LastOff = AW'(LEN - 1);
   localparam int unsigned   WcW     = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [WcW-1:0] WeLast = WcW'(WE_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StCapture,
      StWrite,
      StHold,
      StVfetch,
      StVcmp,
      StDone
   } state_e;

   state_e         state_q;
   logic [DAW-1:0] base_q;
   logic [AW-1:0]  offset_q;
   logic [WcW-1:0] we_cnt_q;
   logic [AW-1:0]  rom_a_q;
   logic [DAW-1:0] sram_a_q;
   logic [7:0]     sram_dout_q;
   logic           sram_we_n_q;

   assign mem.rom_a     = rom_a_q;
   assign mem.sram_a    = sram_a_q;
   assign mem.sram_dout = sram_dout_q;
   assign mem.sram_we_n = sram_we_n_q;

   // rom_a is loaded on entry to FETCH/VFETCH so the registered ROM data is
   // ready one full cycle before CAPTURE/VCMP samples it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         base_q      <= '0;
         offset_q    <= '0;
         we_cnt_q    <= '0;
         rom_a_q     <= '0;
         sram_a_q    <= '0;
         sram_dout_q <= '0;
         sram_we_n_q <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_addr    <= '0;
         checksum    <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  base_q   <= base;
                  offset_q <= '0;
                  rom_a_q  <= '0;
                  checksum <= '0;
                  error    <= 1'b0;
                  err_addr <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state_q  <= StFetch;
               end
            end
            StFetch: begin
               state_q <= StCapture;
            end
            StCapture: begin
               sram_dout_q <= mem.rom_dout;
               sram_a_q    <= base_q + DAW'(offset_q);
               checksum    <= checksum + mem.rom_dout;
               we_cnt_q    <= '0;
               state_q     <= StWrite;
            end
            StWrite: begin
               sram_we_n_q <= 1'b0;
               if (we_cnt_q == WeLast) begin
                  state_q <= StHold;
               end else begin
                  we_cnt_q <= we_cnt_q + WcW'(1);
               end
            end
            StHold: begin
               sram_we_n_q <= 1'b1;
               if (offset_q == LastOff) begin
                  offset_q <= '0;
                  rom_a_q  <= '0;
                  state_q  <= StVfetch;
               end else begin
                  offset_q <= offset_q + AW'(1);
                  rom_a_q  <= offset_q + AW'(1);
                  state_q  <= StFetch;
               end
            end
            StVfetch: begin
               // Address moves only here, a full cycle after the last strobe rose.
               sram_a_q    <= base_q + DAW'(offset_q);
               sram_we_n_q <= 1'b1;
               state_q     <= StVcmp;
            end
            StVcmp: begin
               if (mem.rom_dout != mem.sram_din) begin
                  error    <= 1'b1;
                  err_addr <= offset_q;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state_q  <= StDone;
               end else if (offset_q == LastOff) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  offset_q <= offset_q + AW'(1);
                  rom_a_q  <= offset_q + AW'(1);
                  state_q  <= StVfetch;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time copy engine that sits on the initiator side of the on-chip synchronous ROM (14-bit address, registered 8-bit data, one-cycle read latency). On a start pulse it reads LEN bytes from the ROM and writes them to external SRAM at a programmable base address. It then reads every byte back and compares it against the ROM. It reports busy, done, an 8-bit additive checksum, and the first failing offset. The SRAM tester and boot paths use it to stage ROM images into SRAM.

## Interface
- AW, 14, ROM address width.
- DAW, 19, SRAM address width.
- LEN, 16384, number of bytes copied (1..2^AW).
- WE_CYCLES, 2, width of sram_we_n low pulse in clocks (>=1).

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- base  in  DAW  SRAM destination base; latched when start is accepted.
- rom_a  out  AW  ROM address.
- rom_dout  in  8  ROM data, valid the cycle after rom_a is presented.
- sram_a  out  DAW  SRAM address.
- sram_dout  out  8  SRAM write data.
- sram_din  in  8  SRAM read data; valid one cycle after sram_a is stable with sram_we_n high.
- sram_we_n  out  1  SRAM write strobe, active low.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  level; high in DONE until the next accepted start.
- error  out  1  verify mismatch flag; valid when done=1.
- err_addr  out  AW  offset of the first mismatch.
- checksum  out  8  mod-256 sum of all bytes read in the copy phase.

## Operation
- All outputs are registered. Reset values are:
  - rom_a=0, sram_a=0, sram_dout=0
  - sram_we_n=1
  - busy=0, done=0, error=0
  - err_addr=0, checksum=0
  - state=IDLE
- States are IDLE, FETCH, CAPTURE, WRITE, HOLD, VFETCH, VCMP and DONE.
- IDLE/DONE with start=1:
  - latch base; clear the internal offset, checksum, error and err_addr
  - set busy=1, done=0; go to FETCH
- FETCH: rom_a=offset. Go to CAPTURE.
- CAPTURE (rom_dout valid):
  - sram_dout=rom_dout
  - sram_a=(base+offset) mod 2^DAW; the sum wraps and there is no carry out
  - checksum+=rom_dout mod 256
  - go to WRITE
- WRITE: sram_we_n=0 for exactly WE_CYCLES cycles; sram_a and sram_dout are held. Go to HOLD.
- HOLD: sram_we_n=1 while address and data stay held for one cycle.
  - If offset==LEN-1: offset=0, go to VFETCH.
  - Otherwise: offset+=1, go to FETCH.
- VFETCH: rom_a=offset, sram_a=base+offset, sram_we_n=1. Go to VCMP.
- VCMP compares rom_dout with sram_din.
  - On mismatch: error=1, err_addr=offset, go to DONE; the remaining bytes are not verified.
  - Else if offset==LEN-1: go to DONE.
  - Otherwise: offset+=1, go to VFETCH.
- DONE: busy=0, done=1. checksum, error and err_addr are held.
- start while busy=1 is ignored, with no queuing.
- The address bus never changes while sram_we_n=0.
- Reset mid-operation: sram_we_n returns to 1 at the next edge. All outputs take their reset values. Any partial SRAM contents are left as-is.

## Timing
- start is sampled at edge E0; busy=1 and FETCH from E0.
- Copy phase: (3+WE_CYCLES) cycles per byte.
- Verify phase: 2 cycles per byte.
- Passing run: done=1 after edge E0+(5+WE_CYCLES)*LEN. With the defaults that is 7*LEN.
- Failing run: done=1 after edge E0+(3+WE_CYCLES)*LEN+2*(k+1), where k is the failing offset.
- The ROM address leads its data by exactly one cycle; rom_dout is never used in the cycle rom_a changes.
- sram_a and sram_dout are stable at least one cycle before sram_we_n falls and one cycle after it rises.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles with random start/base.
  - Required: all outputs at their reset values; sram_we_n=1 throughout.
- Copy with wrap (LEN=16, base=0x7FFF8, ROM[i]=3*i, correct SRAM model):
  - 16 writes to 0x7FFF8..0x7FFFF then 0x00000..0x00007, data 0x00,0x03,...,0x2D
  - checksum=0x68, error=0
  - done=1 exactly 112 cycles after the start edge
- Strobe timing: monitor every write.
  - Required: sram_we_n low for exactly 2 consecutive cycles.
  - Required: sram_a and sram_dout unchanged from one cycle before the fall to one cycle after the rise.
  - Required: no address change while the strobe is low.
- Verify failure: the SRAM model returns a corrupted value for offset 5.
  - Required: error=1, err_addr=5.
  - Required: done=1 at cycle 80+12=92 after start; no VFETCH beyond offset 5.
- Ignored start and mid-run reset:
  - start pulses at cycles 10 and 40 during a run change nothing.
  - rst_n=0 at cycle 23 (inside WRITE): sram_we_n=1 and busy=0 after the next edge.
- Restart from DONE after the failing run: a new start with a correct SRAM model.
  - Required: done and error cleared at the start edge; the run completes with error=0.
